// File: rtl/dircc_send_scheduler_if.sv
// Message channel from the send scheduler toward the network interface.
// The master drives a message and holds it until the slave accepts it.
interface dircc_send_scheduler_if #(
  parameter int PAYLOAD_WIDTH = 64
);
  logic                     tx_valid;
  logic                     tx_ready;
  logic [4:0]               tx_port;
  logic [PAYLOAD_WIDTH-1:0] tx_data;

  modport master (
    output tx_valid,
    output tx_port,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_port,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/dircc_send_scheduler.sv
// Round-robin send scheduler: picks the next port with a pending message,
// fetches its payload, presents it on the tx channel and holds off for a
// fixed number of cycles after every send so device state can settle.
// Optional send watchdog: define DIRCC_SEND_TIMEOUT_EN to abandon a message
// that is not accepted within TIMEOUT_CYCLES cycles (sticky timeout_err).
//
// state     | meaning
// S_IDLE    | waiting for any rts_ready bit; grant loads port_sel
// S_SELECT  | dev_payload for port_sel is valid; capture it into tx regs
// S_SEND    | tx_valid high, message held until tx_ready
// S_HOLDOFF | post-send gap, rts_ready ignored until counter expires
module dircc_send_scheduler #(
  parameter int NUM_PORTS      = 4,
  parameter int PAYLOAD_WIDTH  = 64,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              rts_ready,
  output logic [4:0]               port_sel,
  input  logic [PAYLOAD_WIDTH-1:0] dev_payload,
  dircc_send_scheduler_if.master   tx,
  output logic                     send_done,
  output logic [4:0]               send_done_port,
  output logic                     busy,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SELECT  = 2'd1,
    S_SEND    = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [4:0]               port_sel_q;
  logic [4:0]               tx_port_q;
  logic [PAYLOAD_WIDTH-1:0] tx_data_q;
  logic [4:0]               last_port_q;
  logic                     done_q;
  logic [4:0]               done_port_q;
  logic [3:0]               hold_cnt_q;
  logic                     timeout_q;

  logic                     grant_found;
  logic [4:0]               grant_idx;
  logic                     handshake;
  logic                     timeout_hit;
  logic                     unused_rts;

  // Bits at or above NUM_PORTS never take part in arbitration.
  assign unused_rts = ^rts_ready;

  // Out-of-range parameters leave this net undriven so lint flags it.
  if (NUM_PORTS < 1 || NUM_PORTS > 32 || HOLDOFF_CYCLES < 1 ||
      HOLDOFF_CYCLES > 15 || TIMEOUT_CYCLES < 1) begin : g_param_range_violated
    logic param_range_violated;
  end

  // Round-robin search starting just above the last port served.
  always_comb begin
    int sum;
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum = int'(last_port_q) + 1 + i;
      if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
      if (!grant_found && rts_ready[sum[4:0]]) begin
        grant_found = 1'b1;
        grant_idx   = sum[4:0];
      end
    end
  end

  assign handshake = (state_q == S_SEND) && tx.tx_ready;

`ifdef DIRCC_SEND_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TO_W-1:0] to_cnt_q;

  assign timeout_hit = (state_q == S_SEND) && !tx.tx_ready && (to_cnt_q == '0);

  // Watchdog down-counter: armed on entry to SEND, terminal count aborts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else if (state_q == S_SELECT) begin
      to_cnt_q <= TO_W'(TIMEOUT_CYCLES - 1);
    end else if (state_q == S_SEND && to_cnt_q != '0) begin
      to_cnt_q <= to_cnt_q - 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         timeout_q <= 1'b0;
    else if (timeout_hit) timeout_q <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_q   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (grant_found) state_d = S_SELECT;
      S_SELECT:  state_d = S_SEND;
      S_SEND:    if (handshake || timeout_hit) state_d = S_HOLDOFF;
      S_HOLDOFF: if (hold_cnt_q <= 4'd1) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy        = (state_q != S_IDLE);
    tx.tx_valid = (state_q == S_SEND);
  end

  // Grant, message capture, completion and holdoff datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_sel_q  <= '0;
      tx_port_q   <= '0;
      tx_data_q   <= '0;
      last_port_q <= 5'(NUM_PORTS - 1);
      done_q      <= 1'b0;
      done_port_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_found) port_sel_q <= grant_idx;
        end
        S_SELECT: begin
          tx_data_q <= dev_payload;
          tx_port_q <= port_sel_q;
        end
        S_SEND: begin
          if (handshake) begin
            done_q      <= 1'b1;
            done_port_q <= tx_port_q;
          end
          if (handshake || timeout_hit) begin
            last_port_q <= tx_port_q;
            hold_cnt_q  <= 4'(HOLDOFF_CYCLES);
          end
        end
        S_HOLDOFF: begin
          if (hold_cnt_q != '0) hold_cnt_q <= hold_cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign port_sel       = port_sel_q;
  assign tx.tx_port     = tx_port_q;
  assign tx.tx_data     = tx_data_q;
  assign send_done      = done_q;
  assign send_done_port = done_port_q;
  assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_dircc_send_scheduler.sv
// Directed bench for the round-robin send scheduler.
module tb_dircc_send_scheduler;
  localparam int NP = 4;
  localparam int PW = 64;
  localparam int HO = 2;
  localparam int TO = 16;

  logic          clk;
  logic          reset_n;
  logic [31:0]   rts_ready;
  logic [4:0]    port_sel;
  logic [PW-1:0] dev_payload;
  logic          send_done;
  logic [4:0]    send_done_port;
  logic          busy;
  logic          timeout_err;
  logic [7:0]    salt;

  int n_cmp;
  int n_bad;

  dircc_send_scheduler_if #(.PAYLOAD_WIDTH(PW)) tx_if ();

  dircc_send_scheduler #(
    .NUM_PORTS(NP), .PAYLOAD_WIDTH(PW), .HOLDOFF_CYCLES(HO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rts_ready(rts_ready), .port_sel(port_sel),
    .dev_payload(dev_payload), .tx(tx_if.master), .send_done(send_done),
    .send_done_port(send_done_port), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] exp_payload(input logic [4:0] p, input logic [7:0] s);
    return 64'hDA7A_0000_0000_0000 | {48'h0, s, 3'b000, p};
  endfunction

  // Upstream send handler: payload depends on the selected port.
  assign dev_payload = exp_payload(port_sel, salt);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    rts_ready      = '0;
    tx_if.tx_ready = 1'b0;
    salt           = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rts_ready = 32'hF; tx_if.tx_ready = 1'b1; salt = '0;
    tick(); tick();
    n_cmp++; if (tx_if.tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got %0b want 0", tx_if.tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (send_done !== 1'b0) begin n_bad++; $display("FAIL reset_send_done got %0b want 0", send_done); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err got %0b want 0", timeout_err); end
    n_cmp++; if (port_sel !== 5'd0) begin n_bad++; $display("FAIL reset_port_sel got %0d want 0", port_sel); end
    n_cmp++; if (tx_if.tx_port !== 5'd0) begin n_bad++; $display("FAIL reset_tx_port got %0d want 0", tx_if.tx_port); end
    n_cmp++; if (send_done_port !== 5'd0) begin n_bad++; $display("FAIL reset_done_port got %0d want 0", send_done_port); end
    n_cmp++; if (tx_if.tx_data !== '0) begin n_bad++; $display("FAIL reset_tx_data got %0h want 0", tx_if.tx_data); end
    rts_ready = '0; tx_if.tx_ready = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_send();
    do_reset();
    rts_ready = 32'h1; tx_if.tx_ready = 1'b1;
    tick();
    n_cmp++; if (tx_if.tx_valid !== 1'b0) begin n_bad++; $display("FAIL single_select_valid got %0b want 0", tx_if.tx_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_select_busy got %0b want 1", busy); end
    tick();
    rts_ready = '0;
    n_cmp++; if (tx_if.tx_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %0b want 1", tx_if.tx_valid); end
    n_cmp++; if (tx_if.tx_port !== 5'd0) begin n_bad++; $display("FAIL single_port got %0d want 0", tx_if.tx_port); end
    n_cmp++; if (tx_if.tx_data !== exp_payload(5'd0, 8'd0)) begin n_bad++; $display("FAIL single_data got %0h want %0h", tx_if.tx_data, exp_payload(5'd0, 8'd0)); end
    tick();
    n_cmp++; if (tx_if.tx_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_drop got %0b want 0", tx_if.tx_valid); end
    n_cmp++; if (send_done !== 1'b1) begin n_bad++; $display("FAIL single_done got %0b want 1", send_done); end
    n_cmp++; if (send_done_port !== 5'd0) begin n_bad++; $display("FAIL single_done_port got %0d want 0", send_done_port); end
    tick();
    n_cmp++; if (send_done !== 1'b0) begin n_bad++; $display("FAIL single_done_pulse got %0b want 0", send_done); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_holdoff_busy got %0b want 1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy got %0b want 0", busy); end
    tick();
    n_cmp++; if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_stay_idle got valid=%0b busy=%0b want 0/0", tx_if.tx_valid, busy); end
    tx_if.tx_ready = 1'b0;
  endtask

  // Records the first NR tx_valid rising edges with cycle index and port.
  task automatic run_grants(input logic [31:0] req, input int nr, output int ports[8],
                            output int when[8], output int dports[8], output int nrise, output int ndone);
    logic prev;
    prev = 1'b0; nrise = 0; ndone = 0;
    rts_ready = req; tx_if.tx_ready = 1'b1;
    for (int c = 0; c < 60 && nrise < nr; c++) begin
      tick();
      if (tx_if.tx_valid && !prev) begin ports[nrise] = int'(tx_if.tx_port); when[nrise] = c; nrise++; end
      if (send_done && ndone < 8) begin dports[ndone] = int'(send_done_port); ndone++; end
      prev = tx_if.tx_valid;
    end
    rts_ready = '0;
  endtask

  task automatic test_round_robin();
    int ports[8]; int when[8]; int dports[8]; int nrise; int ndone;
    int exp_p[5];
    exp_p = '{0, 1, 2, 3, 0};
    do_reset();
    run_grants(32'hF, 5, ports, when, dports, nrise, ndone);
    n_cmp++; if (nrise !== 5) begin n_bad++; $display("FAIL rr_grant_count got %0d want 5", nrise); end
    for (int k = 0; k < 5 && k < nrise; k++) begin
      n_cmp++; if (ports[k] !== exp_p[k]) begin n_bad++; $display("FAIL rr_port[%0d] got %0d want %0d", k, ports[k], exp_p[k]); end
      if (k > 0) begin
        n_cmp++; if (when[k] - when[k-1] !== 3 + HO) begin n_bad++; $display("FAIL rr_spacing[%0d] got %0d want %0d", k, when[k] - when[k-1], 3 + HO); end
      end
    end
    n_cmp++; if (ndone < 4) begin n_bad++; $display("FAIL rr_done_count got %0d want >=4", ndone); end
    for (int k = 0; k < 4 && k < ndone; k++) begin
      n_cmp++; if (dports[k] !== exp_p[k]) begin n_bad++; $display("FAIL rr_done_port[%0d] got %0d want %0d", k, dports[k], exp_p[k]); end
    end
    tx_if.tx_ready = 1'b0;
  endtask

  task automatic test_single_regrant();
    int ports[8]; int when[8]; int dports[8]; int nrise; int ndone;
    do_reset();
    run_grants(32'h8, 2, ports, when, dports, nrise, ndone);
    n_cmp++; if (nrise !== 2) begin n_bad++; $display("FAIL regrant_count got %0d want 2", nrise); end
    else begin
      n_cmp++; if (ports[0] !== 3 || ports[1] !== 3) begin n_bad++; $display("FAIL regrant_ports got %0d,%0d want 3,3", ports[0], ports[1]); end
      n_cmp++; if (when[1] - when[0] !== 3 + HO) begin n_bad++; $display("FAIL regrant_spacing got %0d want %0d", when[1] - when[0], 3 + HO); end
    end
    tx_if.tx_ready = 1'b0;
  endtask

  task automatic test_stall();
    int extra;
    do_reset();
    rts_ready = 32'h4; tx_if.tx_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (tx_if.tx_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid_start got %0b want 1", tx_if.tx_valid); end
    salt = 8'h5A; rts_ready = 32'h1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_port !== 5'd2 || tx_if.tx_data !== exp_payload(5'd2, 8'd0) || send_done !== 1'b0)
        begin n_bad++; $display("FAIL stall_hold[%0d] got v=%0b p=%0d d=%0h done=%0b want 1/2/%0h/0", c, tx_if.tx_valid, tx_if.tx_port, tx_if.tx_data, send_done, exp_payload(5'd2, 8'd0)); end
    end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL stall_timeout_err got %0b want 0", timeout_err); end
    tx_if.tx_ready = 1'b1; rts_ready = '0;
    tick();
    n_cmp++; if (send_done !== 1'b1 || send_done_port !== 5'd2) begin n_bad++; $display("FAIL stall_done got %0b port %0d want 1 port 2", send_done, send_done_port); end
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (send_done || tx_if.tx_valid) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL stall_extra_activity got %0d want 0", extra); end
    tx_if.tx_ready = 1'b0;
  endtask

  task automatic test_ignored_ports();
    logic [31:0] pats[2];
    pats = '{32'h0000_0030, 32'hFFFF_FFF0};
    do_reset();
    tx_if.tx_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      rts_ready = pats[p];
      for (int c = 0; c < 6; c++) begin
        tick();
        n_cmp++; if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0 || send_done !== 1'b0)
          begin n_bad++; $display("FAIL ignored_%0h[%0d] got busy=%0b valid=%0b done=%0b want 0/0/0", pats[p], c, busy, tx_if.tx_valid, send_done); end
      end
    end
    rts_ready = '0; tx_if.tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    rts_ready = 32'h1; tx_if.tx_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (tx_if.tx_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_valid_before got %0b want 1", tx_if.tx_valid); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (tx_if.tx_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid_async got %0b want 0", tx_if.tx_valid); end
    n_cmp++; if (busy !== 1'b0 || send_done !== 1'b0) begin n_bad++; $display("FAIL midrst_busy_done got %0b/%0b want 0/0", busy, send_done); end
    tx_if.tx_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (send_done !== 1'b0 || tx_if.tx_data !== '0) begin n_bad++; $display("FAIL midrst_held got done=%0b data=%0h want 0/0", send_done, tx_if.tx_data); end
    rts_ready = 32'h2;
    reset_n = 1'b1;
    tick(); tick();
    rts_ready = '0;
    n_cmp++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_port !== 5'd1) begin n_bad++; $display("FAIL midrst_first_grant got v=%0b p=%0d want 1/1", tx_if.tx_valid, tx_if.tx_port); end
    tick();
    n_cmp++; if (send_done !== 1'b1 || send_done_port !== 5'd1) begin n_bad++; $display("FAIL midrst_done got %0b port %0d want 1 port 1", send_done, send_done_port); end
    tx_if.tx_ready = 1'b0;
    tick(); tick(); tick();
  endtask

`ifdef DIRCC_SEND_TIMEOUT_EN
  task automatic test_timeout();
    int hi; int dseen; logic got;
    do_reset();
    rts_ready = 32'h3; tx_if.tx_ready = 1'b0;
    tick(); tick();
    hi = 0; dseen = 0;
    for (int c = 0; c < 40; c++) begin
      if (send_done) dseen++;
      if (!tx_if.tx_valid) break;
      hi++;
      tick();
    end
    n_cmp++; if (hi !== TO) begin n_bad++; $display("FAIL to_valid_cycles got %0d want %0d", hi, TO); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_err_set got %0b want 1", timeout_err); end
    n_cmp++; if (dseen !== 0) begin n_bad++; $display("FAIL to_no_done got %0d want 0", dseen); end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (tx_if.tx_valid) got = 1'b1;
    end
    n_cmp++; if (!got || tx_if.tx_port !== 5'd1) begin n_bad++; $display("FAIL to_next_grant got v=%0b p=%0d want 1/1", got, tx_if.tx_port); end
    rts_ready = '0; tx_if.tx_ready = 1'b1;
    tick(); tick(); tick(); tick();
    n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_err_sticky got %0b want 1", timeout_err); end
    do_reset();
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_err_cleared got %0b want 0", timeout_err); end
  endtask
`else
  task automatic test_timeout();
    do_reset();
    rts_ready = 32'h1; tx_if.tx_ready = 1'b0;
    tick(); tick();
    rts_ready = '0;
    for (int c = 0; c < 40; c++) tick();
    n_cmp++; if (tx_if.tx_valid !== 1'b1) begin n_bad++; $display("FAIL nowd_valid_held got %0b want 1", tx_if.tx_valid); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL nowd_err got %0b want 0", timeout_err); end
    tx_if.tx_ready = 1'b1;
    tick();
    n_cmp++; if (send_done !== 1'b1) begin n_bad++; $display("FAIL nowd_done got %0b want 1", send_done); end
    tx_if.tx_ready = 1'b0;
  endtask
`endif

  initial begin
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0; rts_ready = '0; tx_if.tx_ready = 1'b0; salt = '0;
    test_reset();
    test_single_send();
    test_round_robin();
    test_single_regrant();
    test_stall();
    test_ignored_ports();
    test_reset_mid_send();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got hang want finish");
    $fatal(1, "bench did not finish");
  end
endmodule
